// File: rtl/quotient_bcd_converter.sv
// quotient_bcd_converter
//
// Converts a 9-bit divider quotient into three BCD digits. It uses a serial
// double-dabble that takes nine cycles. A quotient equal to ERR_CODE marks a
// divide-by-zero. That case skips the conversion and presents F/F/F with
// error_o set.
//
// Handshake: the result is offered while bcd_valid_o is high (the HOLD state).
// It is consumed on any rising edge where bcd_valid_o and bcd_ready_i are both
// high. bcd_valid_o comes straight from state, never from bcd_ready_i. Once
// raised, bcd_valid_o and the digits do not change until that edge.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      asynchronous, active-high reset
//   quotient_i   divider result, sampled only while finish_i is high
//   finish_i     one-cycle pulse marking quotient_i valid
//   bcd_ready_i  consumer ready to take the presented result
//   busy_o       high while converting (SHIFT)
//   bcd_valid_o  high while the result is presented (HOLD)
//   hundreds_o   BCD hundreds digit (F on error)
//   tens_o       BCD tens digit (F on error)
//   ones_o       BCD ones digit (F on error)
//   error_o      captured quotient was ERR_CODE; meaningful with bcd_valid_o
//   overrun_o    one-cycle pulse after a finish_i pulse was dropped
//   fsm_state    current FSM state, for observation (0 IDLE, 1 SHIFT, 2 HOLD)

module quotient_bcd_converter #(
    parameter logic [8:0] ERR_CODE = 9'h1FF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] quotient_i,
    input  logic       finish_i,
    input  logic       bcd_ready_i,
    output logic       busy_o,
    output logic       bcd_valid_o,
    output logic [3:0] hundreds_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       error_o,
    output logic       overrun_o,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The ninth shift is performed when the counter reads 8.
    localparam logic [3:0] LAST_SHIFT = 4'd8;

    state_t      state;
    state_t      state_next;

    logic [8:0]  shreg;
    logic [11:0] acc;
    logic [3:0]  cnt;
    logic [3:0]  hundreds_q;
    logic [3:0]  tens_q;
    logic [3:0]  ones_q;
    logic        error_q;
    logic        overrun_q;

    logic        accept;
    logic        load_num;
    logic        load_err;
    logic        do_shift;
    logic        overrun_next;
    logic [11:0] acc_adj;
    logic [11:0] acc_shifted;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Double-dabble step: first correct each digit, then shift in the next
    // quotient bit from the top of the shift register.
    always_comb begin
        acc_adj     = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
        acc_shifted = {acc_adj[10:0], shreg[8]};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        load_num     = 1'b0;
        load_err     = 1'b0;
        do_shift     = 1'b0;
        overrun_next = 1'b0;

        case (state)
            IDLE: begin
                accept = finish_i;
            end
            SHIFT: begin
                do_shift = 1'b1;
                if (cnt == LAST_SHIFT) begin
                    state_next = HOLD;
                end
                // The shift register is in use, so a new quotient is dropped.
                if (finish_i) begin
                    overrun_next = 1'b1;
                end
            end
            HOLD: begin
                if (bcd_ready_i) begin
                    // On the handshake edge a new quotient can be taken at
                    // once, so IDLE is skipped.
                    accept = finish_i;
                    if (!finish_i) begin
                        state_next = IDLE;
                    end
                end else if (finish_i) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            if (quotient_i == ERR_CODE) begin
                load_err   = 1'b1;
                state_next = HOLD;
            end else begin
                load_num   = 1'b1;
                state_next = SHIFT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shreg      <= 9'd0;
            acc        <= 12'd0;
            cnt        <= 4'd0;
            hundreds_q <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= overrun_next;
            if (load_num) begin
                shreg   <= quotient_i;
                acc     <= 12'd0;
                cnt     <= 4'd0;
                error_q <= 1'b0;
            end else if (load_err) begin
                error_q    <= 1'b1;
                hundreds_q <= 4'hF;
                tens_q     <= 4'hF;
                ones_q     <= 4'hF;
            end else if (do_shift) begin
                acc   <= acc_shifted;
                shreg <= {shreg[7:0], 1'b0};
                cnt   <= cnt + 4'd1;
                if (cnt == LAST_SHIFT) begin
                    hundreds_q <= acc_shifted[11:8];
                    tens_q     <= acc_shifted[7:4];
                    ones_q     <= acc_shifted[3:0];
                end
            end
        end
    end

    assign busy_o      = (state == SHIFT);
    assign bcd_valid_o = (state == HOLD);
    assign hundreds_o  = hundreds_q;
    assign tens_o      = tens_q;
    assign ones_o      = ones_q;
    assign error_o     = error_q;
    assign overrun_o   = overrun_q;
    assign fsm_state   = state;

endmodule

// File: tb/tb_quotient_bcd_converter.sv
// Self-checking bench for quotient_bcd_converter.
//
// The first part runs a table of quotients with hand-computed BCD digits.
// The second part runs hand-written sequences: a long hold, overrun in SHIFT
// and in HOLD, capture on the handshake edge, and reset mid-conversion.
// Inputs change on the falling edge or 1 ns after a rising edge. Outputs are
// sampled on the falling edge.

module tb_quotient_bcd_converter;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] quotient;
    logic       finish;
    logic       bcd_ready;
    logic       busy;
    logic       bcd_valid;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       error;
    logic       overrun;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    quotient_bcd_converter dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .quotient_i  (quotient),
        .finish_i    (finish),
        .bcd_ready_i (bcd_ready),
        .busy_o      (busy),
        .bcd_valid_o (bcd_valid),
        .hundreds_o  (hundreds),
        .tens_o      (tens),
        .ones_o      (ones),
        .error_o     (error),
        .overrun_o   (overrun),
        .fsm_state   (fsm_state)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [8:0]  q;
        logic [11:0] digits;
        logic        err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive a one-cycle finish pulse. On return, the sampling edge has just
    // passed and finish is low again.
    task automatic pulse_finish(input logic [8:0] q);
        @(negedge clk);
        quotient = q;
        finish   = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    // Count edges from the sampling edge until bcd_valid is seen. This
    // matches the "+N edges" wording: lat=1 is the first falling edge.
    task automatic wait_valid(output int lat, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            check("busy_valid_exclusive", {31'd0, busy & bcd_valid}, 32'd0);
            if (bcd_valid) begin
                seen = 1'b1;
            end else if (busy) begin
                busy_cnt++;
            end
        end
    endtask

    function automatic logic [11:0] digits_now();
        return {hundreds, tens, ones};
    endfunction

    initial begin
        int lat;
        int bc;
        logic [11:0] exp_d;

        vecs[0]  = '{9'd0,   12'h000, 1'b0};
        vecs[1]  = '{9'd255, 12'h255, 1'b0};
        vecs[2]  = '{9'd510, 12'h510, 1'b0};
        vecs[3]  = '{9'h1FF, 12'hFFF, 1'b1};
        vecs[4]  = '{9'd42,  12'h042, 1'b0};
        vecs[5]  = '{9'd1,   12'h001, 1'b0};
        vecs[6]  = '{9'd9,   12'h009, 1'b0};
        vecs[7]  = '{9'd10,  12'h010, 1'b0};
        vecs[8]  = '{9'd99,  12'h099, 1'b0};
        vecs[9]  = '{9'd100, 12'h100, 1'b0};
        vecs[10] = '{9'd199, 12'h199, 1'b0};
        vecs[11] = '{9'd200, 12'h200, 1'b0};
        vecs[12] = '{9'd341, 12'h341, 1'b0};
        vecs[13] = '{9'd500, 12'h500, 1'b0};
        vecs[14] = '{9'd123, 12'h123, 1'b0};

        // ---------------- reset state ----------------
        reset     = 1'b1;
        quotient  = 9'd0;
        finish    = 1'b0;
        bcd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",    {31'd0, busy},      32'd0);
        check("rst_valid",   {31'd0, bcd_valid}, 32'd0);
        check("rst_error",   {31'd0, error},     32'd0);
        check("rst_overrun", {31'd0, overrun},   32'd0);
        check("rst_digits",  {20'd0, digits_now()}, 32'd0);
        check("rst_state",   {30'd0, fsm_state}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- table of conversions ----------------
        for (int i = 0; i < 15; i++) begin
            bcd_ready = 1'b1;
            exp_q.push_back(vecs[i].digits);
            pulse_finish(vecs[i].q);
            wait_valid(lat, bc);
            exp_d = exp_q.pop_front();
            check("tbl_latency", lat, vecs[i].err ? 32'd1 : 32'd10);
            check("tbl_busy_cycles", bc, vecs[i].err ? 32'd0 : 32'd9);
            check("tbl_digits", {20'd0, digits_now()}, {20'd0, exp_d});
            check("tbl_error", {31'd0, error}, {31'd0, vecs[i].err});
            // The handshake edge has passed: back to IDLE, digits held.
            @(negedge clk);
            check("tbl_valid_drop", {31'd0, bcd_valid}, 32'd0);
            check("tbl_idle_state", {30'd0, fsm_state}, 32'd0);
            check("tbl_idle_digits", {20'd0, digits_now()}, {20'd0, exp_d});
            check("tbl_overrun", {31'd0, overrun}, 32'd0);
        end

        // ---------------- long hold with ready low (123) ----------------
        bcd_ready = 1'b0;
        pulse_finish(9'd123);
        wait_valid(lat, bc);
        check("hold_latency", lat, 32'd10);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, bcd_valid}, 32'd1);
            check("hold_digits", {20'd0, digits_now()}, 32'h123);
        end
        bcd_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", {31'd0, bcd_valid}, 32'd0);
        check("hold_release_state", {30'd0, fsm_state}, 32'd0);

        // ---------------- overrun during SHIFT ----------------
        pulse_finish(9'd50);
        @(negedge clk);
        @(negedge clk);
        quotient = 9'd77;
        finish   = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        @(negedge clk);
        check("shift_overrun_pulse", {31'd0, overrun}, 32'd1);
        check("shift_overrun_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("shift_overrun_clear", {31'd0, overrun}, 32'd0);
        wait_valid(lat, bc);
        check("shift_overrun_seen_valid", {31'd0, bcd_valid}, 32'd1);
        check("shift_overrun_digits", {20'd0, digits_now()}, 32'h050);
        check("shift_overrun_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        check("shift_overrun_idle", {30'd0, fsm_state}, 32'd0);

        // ---------------- overrun in HOLD, then capture on handshake ----------------
        bcd_ready = 1'b0;
        pulse_finish(9'd20);
        wait_valid(lat, bc);
        check("hs_first_latency", lat, 32'd10);
        quotient = 9'd9;
        finish   = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        @(negedge clk);
        check("hold_overrun_pulse", {31'd0, overrun}, 32'd1);
        check("hold_overrun_valid", {31'd0, bcd_valid}, 32'd1);
        check("hold_overrun_digits", {20'd0, digits_now()}, 32'h020);
        // Handshake and a new finish on the same edge.
        bcd_ready = 1'b1;
        quotient  = 9'd7;
        finish    = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        @(negedge clk);
        check("hs_capture_no_overrun", {31'd0, overrun}, 32'd0);
        check("hs_capture_state", {30'd0, fsm_state}, 32'd1);
        wait_valid(lat, bc);
        check("hs_capture_latency", lat + 1, 32'd10);
        check("hs_capture_digits", {20'd0, digits_now()}, 32'h007);
        @(negedge clk);
        check("hs_capture_idle", {30'd0, fsm_state}, 32'd0);

        // ---------------- reset during SHIFT ----------------
        pulse_finish(9'd200);
        repeat (5) @(negedge clk);
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_busy",    {31'd0, busy},      32'd0);
        check("midrst_valid",   {31'd0, bcd_valid}, 32'd0);
        check("midrst_error",   {31'd0, error},     32'd0);
        check("midrst_overrun", {31'd0, overrun},   32'd0);
        check("midrst_digits",  {20'd0, digits_now()}, 32'd0);
        check("midrst_state",   {30'd0, fsm_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("midrst_no_valid", {31'd0, bcd_valid}, 32'd0);
        end
        pulse_finish(9'd42);
        wait_valid(lat, bc);
        check("after_rst_latency", lat, 32'd10);
        check("after_rst_digits", {20'd0, digits_now()}, 32'h042);
        check("after_rst_error", {31'd0, error}, 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
